cache_mem_arbiter: RTL and testbench

Shares the single 32-bit main-memory port between the instruction-cache and data-cache miss paths of `CPUMIPS`. It serialises I-line refills, D-line refills and D-cache single-word write-throughs. Each refill is issued as `BEATS` word reads and assembled into the 128-bit line that feeds the cache's miss-data input. The block sits between the two cache controllers and the memory model or bus.

---
 rtl/cache_mem_arbiter_if.sv | 38 +++
 rtl/cache_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle between the two cache miss paths, the arbiter and the memory port.
// The arbiter connects through 'slave'; the caches and the memory connect through 'master'.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
);
    localparam int LINE_W = DATA_W * BEATS;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [LINE_W-1:0] i_line;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [LINE_W-1:0] d_line;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ready, i_line, d_ready, d_line, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ready, i_line, d_ready, d_line, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port between I-line refills,
// D-line refills and D-cache single-word write-throughs.
//
// state  | meaning
// IDLE   | sample i_req/d_req, grant round-robin on a tie
// FILL   | read BEATS words of the owner's line, one per mem_ack
// WRITE  | single-word write of the registered D address/data
// RESP   | owner's ready pulse; requests are not sampled
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input logic                 clk,
    input logic                 rstn,
    cache_mem_arbiter_if.slave  bus
);
    localparam int LINE_W = DATA_W * BEATS;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WORD_B = DATA_W / 8;
    localparam int LINE_B = LINE_W / 8;
    localparam int WORD_OFF = $clog2(WORD_B);

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] beat_nxt;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              grant;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] i_line_q, i_line_d;
    logic [LINE_W-1:0] d_line_q, d_line_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_B - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(WORD_B - 1);
    endfunction

    assign beat_nxt = beat_q + BEAT_W'(1);

    // On a tie the port that did not win last time gets the grant.
    assign grant = (bus.i_req && bus.d_req) ? ~last_grant_q : bus.d_req;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_line_d     = i_line_q;
        d_line_d     = d_line_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    beat_d       = '0;
                    mem_req_d    = 1'b1;
                    if (grant == OWN_I) begin
                        base_d     = line_base(bus.i_addr);
                        mem_addr_d = line_base(bus.i_addr);
                        mem_we_d   = 1'b0;
                        state_d    = S_FILL;
                    end else if (bus.d_we) begin
                        mem_addr_d  = word_align(bus.d_addr);
                        mem_wdata_d = bus.d_wdata;
                        mem_we_d    = 1'b1;
                        state_d     = S_WRITE;
                    end else begin
                        base_d     = line_base(bus.d_addr);
                        mem_addr_d = line_base(bus.d_addr);
                        mem_we_d   = 1'b0;
                        state_d    = S_FILL;
                    end
                end
            end

            S_FILL: begin
                if (bus.mem_ack && mem_req_q) begin
                    if (owner_q == OWN_I) begin
                        i_line_d[beat_q*DATA_W +: DATA_W] = bus.mem_rdata;
                    end else begin
                        d_line_d[beat_q*DATA_W +: DATA_W] = bus.mem_rdata;
                    end
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_d    = '0;
                        mem_req_d = 1'b0;
                        i_ready_d = (owner_q == OWN_I);
                        d_ready_d = (owner_q == OWN_D);
                        state_d   = S_RESP;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = base_q + (ADDR_W'(beat_nxt) << WORD_OFF);
                    end
                end
            end

            S_WRITE: begin
                if (bus.mem_ack && mem_req_q) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_ready_d = 1'b1;
                    state_d   = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A reset mid-fill discards the partial line along with everything else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            base_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_line_q     <= '0;
            d_line_q     <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_line_q     <= i_line_d;
            d_line_q     <= d_line_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_line    = i_line_q;
    assign bus.d_line    = d_line_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized bench for cache_mem_arbiter: a memory responder with
// wait states feeds a transaction-level model of grants, beats and lines.
module tb_cache_mem_arbiter;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    beat_t        log_q[$];
    logic [31:0]  mem_arr [bit [31:0]];
    int           ack_wait = 0;
    bit           spur = 1'b0;
    int           n_asserts = 0;
    int           n_fail = 0;
    int           m_last = 0;
    logic [127:0] exp_i = '0;
    logic [127:0] exp_d = '0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Memory: acks after ack_wait idle cycles per word, logs every accepted word.
    initial begin : mem_resp
        bit    pend;
        beat_t pb;
        int    waited;
        pend = 1'b0;
        waited = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (pend && rstn) begin
                log_q.push_back(pb);
                if (pb.we) mem_arr[pb.addr] = pb.wdata;
            end
            pend = 1'b0;
            #1;
            if (!rstn) begin
                bus.mem_ack = 1'b0;
                waited = 0;
            end else if (bus.mem_req) begin
                if (waited >= ack_wait) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_rd(bus.mem_addr);
                    pb.addr  = bus.mem_addr;
                    pb.we    = bus.mem_we;
                    pb.wdata = bus.mem_wdata;
                    pend   = 1'b1;
                    waited = 0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    waited++;
                end
            end else begin
                bus.mem_ack   = spur;
                bus.mem_rdata = $urandom;
                waited = 0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_req"}, bus.mem_req, 0);
        check({tag, "_ready"}, {bus.i_ready, bus.d_ready}, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctl"}, {bus.mem_req, bus.mem_we, bus.i_ready, bus.d_ready}, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_i_line"}, bus.i_line, 0);
        check({tag, "_d_line"}, bus.d_line, 0);
    endtask

    task automatic do_reset();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rstn = 1'b1;
        m_last = 0;
        exp_i = '0;
        exp_d = '0;
        log_q.delete();
    endtask

    task automatic wait_ready(output int port, output int cycles);
        port = -1;
        cycles = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.i_ready || bus.d_ready) begin
                check("single_ready", bus.i_ready & bus.d_ready, 0);
                port = bus.d_ready ? 1 : 0;
                break;
            end
        end
        check("ready_seen", port >= 0, 1);
    endtask

    task automatic check_done(input int port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wd);
        logic [31:0]  base;
        logic [127:0] line;
        m_last = port;
        if (port == 1 && we) begin
            check("wr_beats", log_q.size(), 1);
            if (log_q.size() >= 1) begin
                check("wr_addr", log_q[0].addr, addr & ~32'h3);
                check("wr_we", log_q[0].we, 1);
                check("wr_data", log_q[0].wdata, wd);
            end
        end else begin
            base = addr & ~32'hF;
            line = '0;
            check("fill_beats", log_q.size(), 4);
            for (int k = 0; k < 4; k++) begin
                line[32*k +: 32] = mem_rd(base + 32'(4*k));
                if (k < log_q.size()) begin
                    check("fill_addr", log_q[k].addr, base + 32'(4*k));
                    check("fill_we", log_q[k].we, 0);
                end
            end
            if (port == 0) exp_i = line;
            else exp_d = line;
        end
        check("i_line", bus.i_line, exp_i);
        check("d_line", bus.d_line, exp_d);
        log_q.delete();
    endtask

    task automatic run_round(input bit ri, input bit rd, input bit dwe,
                             input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd);
        int order[$];
        int port, cyc;
        if (ri && rd) begin
            if (m_last == 0) begin order.push_back(1); order.push_back(0); end
            else begin order.push_back(0); order.push_back(1); end
        end else if (ri) order.push_back(0);
        else order.push_back(1);
        bus.i_req = ri; bus.i_addr = ia;
        bus.d_req = rd; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
        foreach (order[k]) begin
            wait_ready(port, cyc);
            if (port < 0) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
                return;
            end
            check("grant_order", port, order[k]);
            check_done(port, (port == 1) ? dwe : 1'b0, (port == 1) ? da : ia, dwd);
            @(posedge clk);
            #1;
            check("ready_pulse", {bus.i_ready, bus.d_ready}, 0);
            if (port == 0) bus.i_req = 1'b0;
            else bus.d_req = 1'b0;
        end
    endtask

    initial begin : main
        int port, cyc;
        int sel;
        logic [127:0] d_before;

        do_reset();

        // Reset then I refill with the documented data words.
        mem_arr[32'h10] = 32'h00430820;
        mem_arr[32'h14] = 32'hBADA881E;
        mem_arr[32'h18] = 32'h00000020;
        mem_arr[32'h1C] = 32'hAAAAAAAA;
        ack_wait = 0;
        bus.i_addr = 32'h14;
        bus.i_req = 1'b1;
        wait_ready(port, cyc);
        check("t1_port", port, 0);
        check("t1_latency", cyc, 5);
        check("t1_line", bus.i_line, 128'hAAAAAAAA_00000020_BADA881E_00430820);
        check_done(0, 1'b0, 32'h14, 32'h0);
        @(posedge clk);
        #1;
        check("t1_pulse", bus.i_ready, 0);
        bus.i_req = 1'b0;

        // Simultaneous requests after reset: D first, then I.
        do_reset();
        run_round(1'b1, 1'b1, 1'b0, 32'h200, 32'h30C, 32'h0);

        // D write with three wait states.
        d_before = exp_d;
        ack_wait = 3;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h103; bus.d_wdata = 32'hDEADBEEF;
        cyc = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.d_ready) break;
            check("t3_req", bus.mem_req, 1);
            check("t3_addr", bus.mem_addr, 32'h100);
            check("t3_we", bus.mem_we, 1);
            check("t3_wdata", bus.mem_wdata, 32'hDEADBEEF);
        end
        check("t3_ready", bus.d_ready, 1);
        check("t3_latency", cyc, 5);
        check("t3_d_line_kept", bus.d_line, d_before);
        check_done(1, 1'b1, 32'h103, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("t3_pulse", bus.d_ready, 0);
        bus.d_req = 1'b0;
        ack_wait = 0;

        // Reset in the middle of a fill.
        bus.i_addr = 32'h48;
        bus.i_req = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (log_q.size() >= 2) break;
        end
        check("t4_two_acks", log_q.size(), 2);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("t4_async");
        bus.i_req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_idle_outputs("t4_held");
        end
        rstn = 1'b1;
        m_last = 0; exp_i = '0; exp_d = '0;
        log_q.delete();
        run_round(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0);

        // Spurious ack while idle.
        spur = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check_idle_outputs("t5_spur");
            check("t5_i_line", bus.i_line, exp_i);
            check("t5_d_line", bus.d_line, exp_d);
        end
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_no_beats", log_q.size(), 0);

        // D request raised during an I ready cycle is granted after the following IDLE cycle.
        bus.i_addr = 32'h84;
        bus.i_req = 1'b1;
        wait_ready(port, cyc);
        check("t5_i_port", port, 0);
        check_done(0, 1'b0, 32'h84, 32'h0);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hA4;
        @(posedge clk);
        #1;
        check("t5_resp_no_req", bus.mem_req, 0);
        bus.i_req = 1'b0;
        @(posedge clk);
        #1;
        check("t5_granted", bus.mem_req, 1);
        check("t5_addr", bus.mem_addr, 32'hA0);
        wait_ready(port, cyc);
        check("t5_d_port", port, 1);
        check_done(1, 1'b0, 32'hA4, 32'h0);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;

        // Randomized rounds with wait states and overlapping addresses.
        for (int r = 0; r < 40; r++) begin
            ack_wait = $urandom_range(0, 2);
            sel = $urandom_range(0, 2);
            run_round(sel != 1, sel != 0, 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
